// File: rtl/odometer_scan_display_pkg.sv
// Shared types and 7-segment glyphs for the odometer/trip scanned display.
// Glyph bit order is {a,b,c,d,e,f,g,dp}, active-high.
package odometer_scan_display_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam int BANK_SPLIT = 4;

    localparam logic [7:0] SEG_0     = 8'hfc;
    localparam logic [7:0] SEG_1     = 8'h60;
    localparam logic [7:0] SEG_2     = 8'hda;
    localparam logic [7:0] SEG_3     = 8'hf2;
    localparam logic [7:0] SEG_4     = 8'h66;
    localparam logic [7:0] SEG_5     = 8'hb6;
    localparam logic [7:0] SEG_6     = 8'hbe;
    localparam logic [7:0] SEG_7     = 8'he0;
    localparam logic [7:0] SEG_8     = 8'hfe;
    localparam logic [7:0] SEG_9     = 8'hf6;
    localparam logic [7:0] SEG_BLANK = 8'h00;
    localparam logic [7:0] SEG_DASH  = 8'h02;

    function automatic logic [7:0] seg_encode(input bcd_digit_t d);
        case (d)
            4'd0:    seg_encode = SEG_0;
            4'd1:    seg_encode = SEG_1;
            4'd2:    seg_encode = SEG_2;
            4'd3:    seg_encode = SEG_3;
            4'd4:    seg_encode = SEG_4;
            4'd5:    seg_encode = SEG_5;
            4'd6:    seg_encode = SEG_6;
            4'd7:    seg_encode = SEG_7;
            4'd8:    seg_encode = SEG_8;
            4'd9:    seg_encode = SEG_9;
            default: seg_encode = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/odometer_scan_display_bcd_digit_counter.sv
// One decade of a chained BCD counter; digit updates 1 clk after i_inc_in, clear wins over increment.
// Carry out is combinational so a whole chain ripples within one cycle; no backpressure.
module bcd_digit_counter
    import odometer_scan_display_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_clr,
    input  logic       i_inc_in,
    output logic [3:0] o_digit,
    output logic       o_carry_out
);

    bcd_digit_t r_digit;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_digit <= '0;
        end else if (i_inc_in) begin
            r_digit <= (r_digit == 4'd9) ? 4'd0 : r_digit + 4'd1;
        end
    end

    assign o_digit     = r_digit;
    assign o_carry_out = i_inc_in & (r_digit == 4'd9);

endmodule

// File: rtl/odometer_scan_display.sv
// Odometer + trip BCD meters counted on a divided tick, one selected meter scanned onto two segment banks.
// All outputs registered (1 clk after scan index changes); free-running, no backpressure.
module odometer_scan_display
    import odometer_scan_display_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int TICK_DIV   = 100_000_000,
    parameter int SCAN_DIV   = 100_000,
    parameter int LZ_BLANK   = 0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_activate,
    input  logic                  i_moving,
    input  logic                  i_trip_clr,
    input  logic                  i_disp_sel,
    output logic [7:0]            o_seg1,
    output logic [7:0]            o_seg2,
    output logic [NUM_DIGITS-1:0] o_an,
    output logic                  o_odo_wrap
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(NUM_DIGITS);

    logic [TW-1:0] r_tick_cnt;
    logic          w_tick;

    assign w_tick = (r_tick_cnt == TW'(TICK_DIV - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst || w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + TW'(1);
        end
    end

    logic                         w_inc;
    logic                         w_odo_clr;
    logic                         w_trip_clr;
    logic [NUM_DIGITS:0]          w_odo_chain;
    logic [NUM_DIGITS:0]          w_trip_chain;
    logic [NUM_DIGITS-1:0][3:0]   w_odo;
    logic [NUM_DIGITS-1:0][3:0]   w_trip;
    logic                         w_unused_trip_wrap;

    // Trip shares the increment; its clear overrides so trip_clr on a tick cycle yields zero.
    assign w_inc           = w_tick & i_moving & i_activate;
    assign w_odo_clr       = ~i_activate;
    assign w_trip_clr      = ~i_activate | i_trip_clr;
    assign w_odo_chain[0]  = w_inc;
    assign w_trip_chain[0] = w_inc;
    assign w_unused_trip_wrap = w_trip_chain[NUM_DIGITS];

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digits
        bcd_digit_counter u_odo (
            .i_clk       (i_clk),
            .i_rst       (i_rst),
            .i_clr       (w_odo_clr),
            .i_inc_in    (w_odo_chain[g]),
            .o_digit     (w_odo[g]),
            .o_carry_out (w_odo_chain[g+1])
        );
        bcd_digit_counter u_trip (
            .i_clk       (i_clk),
            .i_rst       (i_rst),
            .i_clr       (w_trip_clr),
            .i_inc_in    (w_trip_chain[g]),
            .o_digit     (w_trip[g]),
            .o_carry_out (w_trip_chain[g+1])
        );
    end

    logic [SW-1:0] r_scan_cnt;
    logic [IW-1:0] r_scan_idx;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_scan_cnt <= '0;
            r_scan_idx <= '0;
        end else if (r_scan_cnt == SW'(SCAN_DIV - 1)) begin
            r_scan_cnt <= '0;
            r_scan_idx <= (r_scan_idx == IW'(NUM_DIGITS - 1)) ? '0 : r_scan_idx + IW'(1);
        end else begin
            r_scan_cnt <= r_scan_cnt + SW'(1);
        end
    end

    logic [NUM_DIGITS-1:0][3:0] w_sel;
    logic [4*NUM_DIGITS-1:0]    w_sel_flat;
    logic                       w_upper_zero;
    logic [7:0]                 w_glyph;

    assign w_sel        = i_disp_sel ? w_trip : w_odo;
    assign w_sel_flat   = w_sel;
    // Scanned digit and everything above it are zero: leading-zero candidate.
    assign w_upper_zero = ((w_sel_flat >> {r_scan_idx, 2'b00}) == '0);

    always_comb begin
        w_glyph = seg_encode(w_sel[r_scan_idx]);
        if (LZ_BLANK != 0 && r_scan_idx != '0 && w_upper_zero) begin
            w_glyph = SEG_BLANK;
        end
        if (!i_activate) begin
            w_glyph = SEG_DASH;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_an       <= NUM_DIGITS'(1);
            o_seg1     <= SEG_BLANK;
            o_seg2     <= SEG_BLANK;
            o_odo_wrap <= 1'b0;
        end else begin
            o_an       <= NUM_DIGITS'(1) << r_scan_idx;
            o_odo_wrap <= w_odo_chain[NUM_DIGITS];
            if (int'(r_scan_idx) < BANK_SPLIT) begin
                o_seg1 <= SEG_BLANK;
                o_seg2 <= w_glyph;
            end else begin
                o_seg1 <= w_glyph;
                o_seg2 <= SEG_BLANK;
            end
        end
    end

endmodule

// File: tb/tb_odometer_scan_display.sv
// Three configurations (4 digits, 8 digits, 4 digits with leading-zero blanking) share random stimulus;
// an integer-valued reference model queues expected outputs, a negedge monitor pops and compares.
module tb_odometer_scan_display;

    localparam int TD = 4;
    localparam int SD = 2;

    logic clk, rst, act, mv, tc, ds;

    logic [3:0] an0, an2;
    logic [7:0] an1;
    logic [7:0] s1_0, s2_0, s1_1, s2_1, s1_2, s2_2;
    logic       w0, w1, w2;

    odometer_scan_display #(.NUM_DIGITS(4), .TICK_DIV(TD), .SCAN_DIV(SD), .LZ_BLANK(0)) u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_activate(act), .i_moving(mv), .i_trip_clr(tc),
        .i_disp_sel(ds), .o_seg1(s1_0), .o_seg2(s2_0), .o_an(an0), .o_odo_wrap(w0));
    odometer_scan_display #(.NUM_DIGITS(8), .TICK_DIV(TD), .SCAN_DIV(SD), .LZ_BLANK(0)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_activate(act), .i_moving(mv), .i_trip_clr(tc),
        .i_disp_sel(ds), .o_seg1(s1_1), .o_seg2(s2_1), .o_an(an1), .o_odo_wrap(w1));
    odometer_scan_display #(.NUM_DIGITS(4), .TICK_DIV(TD), .SCAN_DIV(SD), .LZ_BLANK(1)) u_dut2 (
        .i_clk(clk), .i_rst(rst), .i_activate(act), .i_moving(mv), .i_trip_clr(tc),
        .i_disp_sel(ds), .o_seg1(s1_2), .o_seg2(s2_2), .o_an(an2), .o_odo_wrap(w2));

    typedef struct packed {
        logic [2:0][7:0] an;
        logic [2:0][7:0] s1;
        logic [2:0][7:0] s2;
        logic [2:0]      w;
    } exp_t;

    exp_t q[$];

    int nd[3] = '{4, 8, 4};
    int lz[3] = '{0, 0, 1};
    int m_tick[3], m_odo[3], m_trip[3], m_scnt[3], m_sidx[3];
    int exp_wraps0 = 0, exp_wraps2 = 0, dut_wraps0 = 0, dut_wraps2 = 0;
    int checks = 0, errors = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int pow10(input int n);
        int r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [7:0] glyph(input int d);
        case (d)
            0: return 8'hfc;  1: return 8'h60;  2: return 8'hda;  3: return 8'hf2;
            4: return 8'h66;  5: return 8'hb6;  6: return 8'hbe;  7: return 8'he0;
            8: return 8'hfe;  9: return 8'hf6;  default: return 8'h00;
        endcase
    endfunction

    task automatic model_step();
        exp_t e;
        e = '0;
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                m_tick[k] = 0; m_odo[k] = 0; m_trip[k] = 0; m_scnt[k] = 0; m_sidx[k] = 0;
                e.an[k] = 8'h01;
            end else begin
                int modv, idx, v, upper;
                bit tick;
                logic [7:0] g;
                modv  = pow10(nd[k]);
                tick  = (m_tick[k] == TD - 1);
                idx   = m_sidx[k];
                v     = ds ? m_trip[k] : m_odo[k];
                upper = v / pow10(idx);
                if (!act)                                 g = 8'h02;
                else if (lz[k] != 0 && idx > 0 && upper == 0) g = 8'h00;
                else                                      g = glyph(upper % 10);
                e.an[k] = 8'(1 << idx);
                if (idx < 4) e.s2[k] = g; else e.s1[k] = g;
                e.w[k] = act && tick && mv && (m_odo[k] == modv - 1);
                if (!act) begin
                    m_odo[k] = 0; m_trip[k] = 0;
                end else if (tick && mv) begin
                    m_odo[k]  = (m_odo[k] + 1) % modv;
                    m_trip[k] = tc ? 0 : (m_trip[k] + 1) % modv;
                end else if (tc) begin
                    m_trip[k] = 0;
                end
                m_tick[k] = tick ? 0 : m_tick[k] + 1;
                if (m_scnt[k] == SD - 1) begin
                    m_scnt[k] = 0;
                    m_sidx[k] = (m_sidx[k] + 1) % nd[k];
                end else begin
                    m_scnt[k] = m_scnt[k] + 1;
                end
            end
        end
        if (e.w[0]) exp_wraps0++;
        if (e.w[2]) exp_wraps2++;
        q.push_back(e);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    task automatic check(input string name, input int k, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s dut%0d at %0t: got %h expected %h", name, k, $time, got, want);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                check("an",   0, {4'b0, an0}, e.an[0]);
                check("seg1", 0, s1_0, e.s1[0]);
                check("seg2", 0, s2_0, e.s2[0]);
                check("wrap", 0, {7'b0, w0}, {7'b0, e.w[0]});
                check("an",   1, an1, e.an[1]);
                check("seg1", 1, s1_1, e.s1[1]);
                check("seg2", 1, s2_1, e.s2[1]);
                check("wrap", 1, {7'b0, w1}, {7'b0, e.w[1]});
                check("an",   2, {4'b0, an2}, e.an[2]);
                check("seg1", 2, s1_2, e.s1[2]);
                check("seg2", 2, s2_2, e.s2[2]);
                check("wrap", 2, {7'b0, w2}, {7'b0, e.w[2]});
                if (w0 === 1'b1) dut_wraps0++;
                if (w2 === 1'b1) dut_wraps2++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; act = 1'b1; mv = 1'b1; tc = 1'b0; ds = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        // Ten ticks of plain counting, odometer then trip view.
        repeat (40) step();
        ds = 1'b1;
        repeat (16) step();
        // Random mix of moving, trip clears, view selection and power drops.
        for (int i = 0; i < 600; i++) begin
            mv  = ($urandom_range(0, 3) != 0);
            tc  = ($urandom_range(0, 15) == 0);
            act = ($urandom_range(0, 63) != 0);
            if (i % 5 == 0) ds = $urandom_range(0, 1);
            step();
        end
        // Long powered run guaranteeing at least one 4-digit odometer wrap.
        act = 1'b1; mv = 1'b1; tc = 1'b0;
        for (int i = 0; i < 40100; i++) begin
            tc = ($urandom_range(0, 199) == 0);
            if (i % 9 == 0) ds = $urandom_range(0, 1);
            step();
        end
        tc = 1'b0;
        mv = 1'b0;
        repeat (80) step();
        act = 1'b0;
        repeat (30) step();
        act = 1'b1; mv = 1'b1; ds = 1'b0;
        repeat (40) step();
        repeat (2) step();
        checks++;
        if (dut_wraps0 != exp_wraps0 || exp_wraps0 < 1) begin
            errors++;
            $display("FAIL wrap_count dut0: got %0d expected %0d (at least 1)", dut_wraps0, exp_wraps0);
        end
        checks++;
        if (dut_wraps2 != exp_wraps2) begin
            errors++;
            $display("FAIL wrap_count dut2: got %0d expected %0d", dut_wraps2, exp_wraps2);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
